// File: rtl/mult_unit.sv
// Iterative radix-2^BITS_PER_CYCLE shift-add multiplier serving MULT/MULTU.
// Define MULT_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are all zero.
module mult_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             multstartE,
  input  logic             signedE,
  input  logic             stallE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  output logic             pve,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIXUP
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic                 neg_q, neg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 accept;
  logic                 last_iter;
  logic [WIDTH-1:0]     mplr_shift;

  // Two's complement magnitude; 0x80..0 maps to itself, which is correct read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             is_signed);
    magnitude = (is_signed && v[WIDTH-1]) ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    negate = ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] partial(input logic [2*WIDTH-1:0]      mc,
                                                 input logic [BITS_PER_CYCLE-1:0] digit);
    logic [2*WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (digit[i]) p = p + (mc << i);
    end
    return p;
  endfunction

  assign accept     = (state_q == S_IDLE) && multstartE && !stallE;
  assign mplr_shift = mplr_q >> BITS_PER_CYCLE;

`ifdef MULT_EARLY_OUT_EN
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1)) || (mplr_shift == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(ITERS - 1));
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mcand_d = {{WIDTH{1'b0}}, magnitude(srcaE, signedE)};
          mplr_d  = magnitude(srcbE, signedE);
          neg_d   = signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d   = acc_q + partial(mcand_q, mplr_q[BITS_PER_CYCLE-1:0]);
        mplr_d  = mplr_shift;
        mcand_d = mcand_q << BITS_PER_CYCLE;
        cnt_d   = cnt_q + 1'b1;
        if (last_iter) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        // Sign is applied once at the end so the iteration stays purely unsigned.
        {hi_d, lo_d} = neg_q ? negate(acc_q) : acc_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign pve  = (state_q == S_IDLE);
  assign busy = ~pve;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: behavioural product/latency model plus directed literal checks.
module tb_mult_unit;
  localparam int W   = 32;
  localparam int BPC = 2;
`ifdef MULT_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         multstartE = 1'b0;
  logic         signedE = 1'b0;
  logic         stallE = 1'b0;
  logic [W-1:0] srcaE = '0;
  logic [W-1:0] srcbE = '0;
  logic         pve, busy;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .reset_n(reset_n), .multstartE(multstartE), .signedE(signedE),
    .stallE(stallE), .srcaE(srcaE), .srcbE(srcbE), .pve(pve), .busy(busy),
    .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Full-width product: sign- or zero-extend to 64 bits, low 64 bits of the product are exact.
  function automatic logic [63:0] ref_prod(input logic s, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [63:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Number of cycles pve stays low after acceptance.
  function automatic int ref_lat(input logic s, input logic [W-1:0] b);
    logic [W-1:0] m;
    int bl;
    m  = (s && b[W-1]) ? (32'd0 - b) : b;
    bl = 0;
    for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
    if (bl == 0) bl = 1;
    return EARLY ? ((bl + BPC - 1) / BPC + 1) : (W / BPC + 1);
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return W'($urandom);
    endcase
  endfunction

  // Reference model: one outstanding multiply, countdown to completion.
  logic [63:0] m_pend = '0;
  logic [63:0] m_prod = '0;
  int          m_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_prod <= '0;
      m_left <= 0;
    end else if (m_left == 0) begin
      if (multstartE && !stallE) begin
        m_pend <= ref_prod(signedE, srcaE, srcbE);
        m_left <= ref_lat(signedE, srcbE);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) m_prod <= m_pend;
    end
  end

  always @(negedge clk) begin
    check("pve", {63'd0, pve}, {63'd0, (m_left == 0)});
    check("busy", {63'd0, busy}, {63'd0, (m_left != 0)});
    check("hi", {32'd0, hi}, {32'd0, m_prod[63:32]});
    check("lo", {32'd0, lo}, {32'd0, m_prod[31:0]});
  end

  task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk); #1;
    signedE = s; srcaE = a; srcbE = b; stallE = 1'b0; multstartE = 1'b1;
    @(posedge clk); #1;
    multstartE = 1'b0;
  endtask

  task automatic wait_done(output int low);
    low = 0;
    while (low <= 200) begin
      @(negedge clk);
      if (pve === 1'b1) break;
      low++;
    end
  endtask

  int low;

  initial begin
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_pve", {63'd0, pve}, 64'd1);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    #1 reset_n = 1'b1;

    start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(low);
    check("t1_latency", 64'(low), 64'd17);
    check("t1_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    check("t1_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);

    start(1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done(low);
    check("t2_latency", 64'(low), EARLY ? 64'd3 : 64'd17);
    check("t2_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    check("t2_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);

    start(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done(low);
    check("t3_latency", 64'(low), 64'd17);
    check("t3_hi", {32'd0, hi}, 64'h0000_0000_4000_0000);
    check("t3_lo", {32'd0, lo}, 64'h0000_0000_0000_0000);

    // Stalled request: held off for five cycles, taken on the first unstalled edge.
    @(negedge clk); #1;
    signedE = 1'b0; srcaE = 32'd5; srcbE = 32'd9; multstartE = 1'b1; stallE = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_pve", {63'd0, pve}, 64'd1);
    end
    #1 stallE = 1'b0;
    @(posedge clk); #1;
    multstartE = 1'b0;
    wait_done(low);
    check("t4_latency", 64'(low), EARLY ? 64'd3 : 64'd17);
    check("t4_lo", {32'd0, lo}, 64'd45);
    repeat (3) begin
      @(negedge clk);
      check("t4_single", {63'd0, pve}, 64'd1);
    end

    // Abort mid-multiply; old and partial results must both vanish.
    start(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (8) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("t5_abort_pve", {63'd0, pve}, 64'd1);
    check("t5_abort_hi", {32'd0, hi}, 64'd0);
    check("t5_abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk); #1 reset_n = 1'b1;
    start(1'b0, 32'd6, 32'd7);
    wait_done(low);
    check("t5_hi", {32'd0, hi}, 64'd0);
    check("t5_lo", {32'd0, lo}, 64'd42);

    start(1'b0, 32'h1234_5678, 32'h0000_0001);
    wait_done(low);
    check("t6_latency", 64'(low), EARLY ? 64'd2 : 64'd17);
    check("t6_hi", {32'd0, hi}, 64'd0);
    check("t6_lo", {32'd0, lo}, 64'h0000_0000_1234_5678);

    // Random traffic, including requests while busy and back-to-back starts.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      multstartE = ($urandom_range(0, 2) != 0);
      stallE     = ($urandom_range(0, 3) == 0);
      signedE    = W'($urandom) % 2 == 1;
      srcaE      = pick_operand();
      srcbE      = pick_operand();
    end
    @(negedge clk); #1;
    multstartE = 1'b0;
    stallE     = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative 32x32->64 multiplier in the EX stage. It serves MULT and MULTU.
- It is the responder on the multstartE/pve handshake that the stall logic consumes.
- A start pulse launches a multi-cycle radix-2^k shift-add multiply.
- pve drops while the multiply runs and rises when HI/LO hold the new product. The hazard block keeps F/D stalled for that whole window.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH.
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration. Legal values are 1, 2 and 4, and WIDTH must be divisible by it.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- multstartE  input  1  start request from the E-stage control (MULT/MULTU in E)
- signedE  input  1  1 = MULT (two's complement), 0 = MULTU
- stallE  input  1  E stage held by the hazard unit; blocks acceptance
- srcaE  input  WIDTH  multiplicand (rs)
- srcbE  input  WIDTH  multiplier (rt)
- pve  output  1  product valid: 1 = idle with HI/LO current, 0 = multiply in flight
- busy  output  1  equals ~pve; provided for debug and perf counters
- hi  output  WIDTH  upper half of the last completed product
- lo  output  WIDTH  lower half of the last completed product

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, pve=1, busy=0, hi=0, lo=0. All internal accumulator, operand and counter registers are cleared. Reset during BUSY or FIXUP aborts the operation, and no partial result reaches hi/lo.
- States: IDLE, BUSY, FIXUP.
- Acceptance happens when all of the following hold at a rising edge:
  - state=IDLE
  - multstartE=1
  - stallE=0
- At the accepting edge:
  - Latch |srcaE| and |srcbE| (the magnitudes are taken only when signedE=1). Latch the result sign as srcaE[MSB]^srcbE[MSB] when signedE=1, else 0.
  - Clear the accumulator, set the counter to 0, go to BUSY, and drive pve=0.
- While multstartE=1 and stallE=1 (a D-cache miss in M), the request is not taken. The unit stays IDLE with pve=1, and the request is retried each cycle.
- BUSY:
  - Each edge adds multiplicand*(the low BITS_PER_CYCLE multiplier bits) into the accumulator. The multiplier shifts right and the multiplicand shifts left by BITS_PER_CYCLE.
  - The counter increments each edge. After WIDTH/BITS_PER_CYCLE iterations the state moves to FIXUP.
  - Accumulator width is 2*WIDTH. Unsigned arithmetic is used throughout, and no overflow is possible.
- FIXUP (one edge):
  - If the sign is 1, write the two's complement negation of the accumulator; otherwise write the accumulator.
  - Write {hi,lo} from that value, set pve=1 and return to IDLE.
  - hi/lo and pve therefore change on the same edge.
- Latency at default: the accepting edge, then 16 BUSY edges, then 1 FIXUP edge. pve is low for exactly 17 cycles and is high after the 18th edge, counted from the accepting edge.
- multstartE while BUSY or FIXUP is ignored, with no queueing.
- A multstartE seen in IDLE on the cycle right after FIXUP is accepted normally, so back-to-back multiplies work.
- hi/lo hold their value in IDLE and during BUSY; the old product stays readable until FIXUP writes the new one.
- Operand inputs are don't-care outside the accepting edge.
- The signed case -2^31 * -2^31 = 2^62 must be exact; the magnitude of 0x80000000 is 0x80000000 unsigned.

Optional Feature:
- MULT_EARLY_OUT_EN defined:
  - In BUSY, if the remaining shifted multiplier equals 0, go to FIXUP on that edge instead of continuing to iterate.
  - Latency becomes data-dependent. The minimum is acceptance, then 1 BUSY edge, then FIXUP, for example when srcbE=0 or srcbE=1. The maximum equals the fixed latency.
  - Results are identical to the non-early-out build.
- Not defined: a fixed WIDTH/BITS_PER_CYCLE iterations for every operand pair.

Test Plan:
- Deassert reset_n and check: pve=1, hi=0, lo=0. Then pulse multstartE with signedE=0, srcaE=0xFFFFFFFF, srcbE=0xFFFFFFFF. Required: pve=0 for 17 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
- signedE=1, srcaE=0xFFFFFFFD (-3), srcbE=0x00000007. Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- signedE=1, srcaE=srcbE=0x80000000. Required: hi=0x40000000, lo=0x00000000.
- Hold multstartE=1 with stallE=1 for 5 cycles, then drop stallE. Required: pve stays 1 during the stall, acceptance happens on the first cycle with stallE=0, and exactly one product is computed.
- Drop reset_n mid-BUSY, 8 cycles in. Required: pve=1 immediately, hi/lo=0, and a following multiply of 6*7 gives lo=42.
- With MULT_EARLY_OUT_EN, srcaE=0x12345678, srcbE=1. Required: pve low for 2 cycles, hi=0, lo=0x12345678.
